// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type, default width and watchdog sizing for the multiplier controller
package mult_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DONE,
      ERR
   } mult_state_t;

   // One spare bit so the count can reach WIDTH itself without wrapping.
   function automatic int wdog_bits(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mult_watchdog.sv
// rtl/mult_watchdog.sv - counts RUN cycles; expired marks the cycle that completes WIDTH of them
module mult_watchdog
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = wdog_bits(WIDTH);

   logic [CW-1:0] r_count;
   logic          w_last;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign w_last  = (r_count == CW'(WIDTH - 1));
   assign expired = enable && w_last;

endmodule

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - shift-add multiplier sequencer (IDLE/LOAD/RUN/DONE/ERR) with RUN watchdog
// Optional EARLY_TERM_EN: mplr_zero in RUN ends the operation without a strobe.
module mult_controller
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   input  logic mplr_lsb,
   input  logic mplr_zero,
   input  logic count_check,
   output logic load_words,
   output logic add_shift,
   output logic shift,
   output logic ready,
   output logic done,
   output logic err
);

   mult_state_t r_state;
   logic        r_ready;
   logic        r_done;
   logic        r_err;
   logic        r_load;
   logic        r_run;

   logic        w_zero_term;
   logic        w_run_op;
   logic        w_clear;
   logic        w_expired;

`ifdef EARLY_TERM_EN
   assign w_zero_term = mplr_zero;
`else
   logic w_unused_zero;
   assign w_unused_zero = mplr_zero;
   assign w_zero_term   = 1'b0;
`endif

   assign w_clear = (r_state == IDLE) && start && !abort;

   mult_watchdog #(
      .WIDTH   (WIDTH)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .enable  (r_run),
      .expired (w_expired)
   );

   // Flags are registered alongside the state so each equals "state is X".
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_load  <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_load  <= 1'b0;
         r_run   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_state <= LOAD;
                  r_load  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= RUN;
                  r_run   <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else if (w_zero_term || count_check) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (w_expired) begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
               end else begin
                  r_state <= RUN;
                  r_run   <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            ERR: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= ERR;
                  r_err   <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Strobes follow the live datapath bits and drop in the cycle abort is seen.
   assign w_run_op   = r_run && !abort && !w_zero_term;
   assign add_shift  = w_run_op && mplr_lsb;
   assign shift      = w_run_op && !mplr_lsb;
   assign load_words = r_load && !abort;
   assign done       = r_done && !abort;
   assign ready      = r_ready;
   assign err        = r_err;

endmodule

// File: tb/tb_mult_controller.sv
// tb/tb_mult_controller.sv - randomized and directed self-checking bench for mult_controller
module tb_mult_controller;

   localparam int WIDTH = 16;

`ifdef EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;
   localparam int M_DONE = 3;
   localparam int M_ERR  = 4;

   logic clk = 1'b0;
   logic reset, start, abort, mplr_lsb, mplr_zero, count_check;
   logic load_words, add_shift, shift, ready, done, err;

   mult_controller #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .mplr_lsb    (mplr_lsb),
      .mplr_zero   (mplr_zero),
      .count_check (count_check),
      .load_words  (load_words),
      .add_shift   (add_shift),
      .shift       (shift),
      .ready       (ready),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int               n_vec = 0;
   int               n_bad = 0;
   bit               chk_en = 1'b0;
   int               m_mode = M_IDLE;
   int               m_runs = 0;
   logic [WIDTH-1:0] pattern = '0;
   bit               cc_kill = 1'b0;
   logic [5:0]       got_v, exp_v;

   // Reference: which phase the operation is in and how many RUN cycles have elapsed.
   always @(posedge clk) begin
      if (!reset) begin
         m_mode = M_IDLE;
         m_runs = 0;
      end else if (abort) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: if (start) m_mode = M_LOAD;
            M_LOAD: begin m_mode = M_RUN; m_runs = 0; end
            M_RUN: begin
               m_runs = m_runs + 1;
               if ((EARLY && mplr_zero) || count_check) m_mode = M_DONE;
               else if (m_runs == WIDTH) m_mode = M_ERR;
            end
            M_DONE: m_mode = M_IDLE;
            default: ;
         endcase
      end
   end

   function automatic logic [5:0] expect_out();
      logic op;
      op = (m_mode == M_RUN) && !abort && !(EARLY && mplr_zero);
      return {(m_mode == M_IDLE), (m_mode == M_DONE) && !abort, (m_mode == M_ERR),
              (m_mode == M_LOAD) && !abort, op && mplr_lsb, op && !mplr_lsb};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         got_v = {ready, done, err, load_words, add_shift, shift};
         exp_v = expect_out();
         n_vec++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs t=%0t mode=%0d runs=%0d got=%b exp=%b (ready,done,err,load,add,shift)",
                     $time, m_mode, m_runs, got_v, exp_v);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Behave like the datapath: shifted multiplier bits and a counter flag on RUN cycle WIDTH.
   task automatic drive_dp();
      int               idx;
      logic [WIDTH-1:0] rem;
      idx         = (m_mode == M_RUN) ? m_runs : 0;
      rem         = pattern >> idx;
      mplr_lsb    = rem[0];
      mplr_zero   = (rem == '0);
      count_check = (m_mode == M_RUN) && (m_runs == WIDTH - 1) && !cc_kill;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_dp();
   endtask

   task automatic run_txn(input logic [WIDTH-1:0] pat, input bit kill, input int abort_run,
                          input int reset_run, input int cycles,
                          output int done_edge, output int err_edge, output int loads,
                          output int done_cnt, output logic [WIDTH-1:0] add_mask,
                          output logic [WIDTH-1:0] shift_mask);
      pattern    = pat;
      cc_kill    = kill;
      start      = 1'b1;
      abort      = 1'b0;
      tick();
      start      = 1'b0;
      done_edge  = -1;
      err_edge   = -1;
      loads      = 0;
      done_cnt   = 0;
      add_mask   = '0;
      shift_mask = '0;
      for (int n = 1; n <= cycles; n++) begin
         abort = (abort_run > 0) && (m_mode == M_RUN) && (m_runs == abort_run - 1);
         reset = !((reset_run > 0) && (m_mode == M_RUN) && (m_runs == reset_run - 1));
         @(negedge clk);
         if (load_words) loads++;
         if (add_shift && n >= 2 && n - 2 < WIDTH) add_mask[n-2] = 1'b1;
         if (shift && n >= 2 && n - 2 < WIDTH) shift_mask[n-2] = 1'b1;
         if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = n;
         end
         if (err && err_edge < 0) err_edge = n;
         tick();
      end
      abort = 1'b0;
      reset = 1'b1;
   endtask

   int               d_edge, e_edge, n_load, n_done;
   logic [WIDTH-1:0] a_mask, s_mask;

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      mplr_lsb = 1'b0; mplr_zero = 1'b0; count_check = 1'b0;
      repeat (3) tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_state", 32'({ready, done, err, load_words, add_shift, shift}), 32'h20);
      tick();
      reset = 1'b1;
      tick();

      // 0x0003 LSB-first: two accumulates then shifts, done sampled 18 edges after start.
      run_txn(16'h0003, 1'b0, 0, 0, 22, d_edge, e_edge, n_load, n_done, a_mask, s_mask);
      check("t1_loads", 32'(n_load), 32'd1);
      check("t1_add_mask", 32'(a_mask), 32'h0003);
      check("t1_shift_mask", 32'(s_mask), EARLY ? 32'h0000 : 32'hFFFC);
      check("t1_done_edge", 32'(d_edge), EARLY ? 32'd5 : 32'd18);
      check("t1_done_once", 32'(n_done), 32'd1);

      // Abort in RUN cycle 5.
      run_txn(16'hA5C3, 1'b0, 5, 0, 10, d_edge, e_edge, n_load, n_done, a_mask, s_mask);
      check("t2_no_done", 32'(n_done), 32'd0);
      check("t2_strobes", 32'($countones(a_mask | s_mask)), 32'd4);
      @(negedge clk);
      check("t2_ready", 32'(ready), 32'd1);
      tick();

      // Missing count_check drives the watchdog into ERR, held until abort.
      run_txn(16'hFFFF, 1'b1, 0, 0, 22, d_edge, e_edge, n_load, n_done, a_mask, s_mask);
      check("t3_err_edge", 32'(e_edge), 32'd18);
      check("t3_strobes", 32'($countones(a_mask | s_mask)), 32'd16);
      check("t3_no_done", 32'(n_done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("t3_err_held", 32'({ready, err}), 32'h1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("t3_abort_exit", 32'({ready, err}), 32'h2);
      tick();

      // Multiplier 0x0001: early termination when enabled, full length otherwise.
      run_txn(16'h0001, 1'b0, 0, 0, 22, d_edge, e_edge, n_load, n_done, a_mask, s_mask);
      check("t4_done_edge", 32'(d_edge), EARLY ? 32'd4 : 32'd18);
      check("t4_add_mask", 32'(a_mask), 32'h0001);

      // Reset in RUN cycle 8, then start with abort in IDLE.
      run_txn(16'h1234, 1'b0, 0, 8, 12, d_edge, e_edge, n_load, n_done, a_mask, s_mask);
      check("t5_no_done", 32'(n_done), 32'd0);
      @(negedge clk);
      check("t5_reset_vals", 32'({ready, done, err, load_words, add_shift, shift}), 32'h20);
      tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("t5_start_abort", 32'({ready, done, err, load_words, add_shift, shift}), 32'h20);
      tick();

      for (int c = 0; c < 3000; c++) begin
         if (m_mode == M_IDLE) begin
            pattern = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
            cc_kill = ($urandom_range(0, 9) == 0);
            drive_dp();
         end
         start = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 40) == 0);
         reset = ($urandom_range(0, 150) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16: the multiplier width, equal to the number of RUN iterations.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request for a new multiplication.
REQ-005 SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-006 SHALL have port mplr_lsb, input, 1 bit: the current LSB of the datapath's shifted multiplier.
REQ-007 SHALL have port mplr_zero, input, 1 bit: high when the remaining shifted multiplier is all zero.
REQ-008 SHALL have port count_check, input, 1 bit: datapath counter flag, high during the final iteration.
REQ-009 SHALL have port load_words, output, 1 bit: datapath operand-load strobe.
REQ-010 SHALL have port add_shift, output, 1 bit: datapath accumulate-then-shift strobe.
REQ-011 SHALL have port shift, output, 1 bit: datapath shift-only strobe.
REQ-012 SHALL have port ready, output, 1 bit: controller idle and able to accept start.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-014 SHALL have port err, output, 1 bit: watchdog fault flag.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RUN, DONE and ERR.
REQ-016 In IDLE, ready SHALL be 1; start=1 with abort=0 SHALL move to LOAD; otherwise the state SHALL stay IDLE.
REQ-017 LOAD SHALL last exactly 1 cycle, drive load_words=1 and then move to RUN.
REQ-018 In each RUN cycle, exactly one of add_shift or shift SHALL be 1: add_shift when mplr_lsb=1, shift when mplr_lsb=0.
REQ-019 In RUN, count_check=1 SHALL still issue that cycle's operation, then move to DONE.
REQ-020 DONE SHALL last 1 cycle with done=1, then return to IDLE; a start in DONE SHALL be ignored.
REQ-021 Start-to-done latency SHALL be exactly WIDTH+2 rising edges after the edge that samples start (LOAD 1, RUN WIDTH, DONE 1).
REQ-022 A watchdog SHALL count RUN cycles; if WIDTH RUN cycles have completed without count_check, the next state SHALL be ERR.
REQ-023 In ERR, err SHALL be 1, all strobes and ready SHALL be 0, and only abort or reset SHALL exit to IDLE.
REQ-024 abort=1 in LOAD, RUN, DONE or ERR SHALL force IDLE on the next edge with no done pulse; in the abort cycle, strobes SHALL be 0.
REQ-025 abort SHALL take priority over start when both are 1, in every state.
REQ-026 Outside LOAD and RUN, load_words, add_shift and shift SHALL all be 0.
REQ-027 The outputs SHALL never be 1 simultaneously for load_words, add_shift and shift.
REQ-028 The watchdog counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL clear on entry to LOAD.

Reset
REQ-029 With reset=0 at a rising edge, the next state SHALL be IDLE: ready=1; done, err and all strobes 0; watchdog counter 0.
REQ-030 Reset SHALL take precedence over start and abort, and SHALL apply in every state, including mid-RUN.

Configuration
REQ-031 With EARLY_TERM_EN defined, mplr_zero=1 in a RUN cycle SHALL issue no strobe and move directly to DONE.
REQ-032 Without EARLY_TERM_EN, mplr_zero SHALL be ignored and RUN SHALL always last until count_check.

Structure
REQ-033 The state enum type mult_state_t and the constant DEFAULT_WIDTH=16 SHALL reside in package mult_pkg.
REQ-034 The watchdog counter SHALL be the single sub-module, mult_watchdog, with inputs clear and enable and output expired.

Verification
REQ-035 The bench SHALL cover this case: reset released, start pulse, mplr_lsb pattern 16'h0003 LSB-first, count_check on the 16th RUN cycle -> load_words 1 cycle; add_shift in RUN cycles 1-2, shift in RUN cycles 3-16; done exactly 18 edges after start.
REQ-036 The bench SHALL cover this case: abort asserted in RUN cycle 5 -> IDLE next edge, done never asserted, ready=1.
REQ-037 The bench SHALL cover this case: count_check held 0 throughout RUN -> ERR after 16 RUN cycles, err=1 held; abort -> IDLE.
REQ-038 The bench SHALL cover this case: with EARLY_TERM_EN defined, multiplier 16'h0001 and mplr_zero=1 from RUN cycle 2 -> done 4 edges after start; without the macro, done at 18 edges.
REQ-039 The bench SHALL cover this case: reset=0 asserted in RUN cycle 8 -> IDLE with every output at its reset value; a start with abort=1 in IDLE -> stays IDLE.
